// File: rtl/spi_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_cfg_pkg
// Description : Shared definitions for the SPI configuration master:
//               peripheral register map, frame layout and FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_cfg_pkg;

    // Peripheral register map
    localparam logic [6:0] ADDR_EN_OUT_UO  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_UIO = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_UO  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_UIO = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY   = 7'h04;

    // Frame layout: {write flag, 7-bit address, 8-bit data}, MSB first
    localparam logic WRITE_FLAG = 1'b1;
    localparam int   FRAME_BITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_GAP   = 3'd4
    } spi_cfg_state_t;

    function automatic logic [15:0] build_frame(input logic [6:0] addr,
                                                input logic [7:0] data);
        return {WRITE_FLAG, addr, data};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_half_period_timer.sv
`default_nettype none
// ============================================================================
// Module      : spi_half_period_timer
// Description : Loadable down-counter shared by every timed FSM state.
//               After a load of N, expire is high for exactly one cycle, N
//               cycles after the load edge (i.e. on the Nth cycle of the
//               state that issued the load).
// Ports       : clk, rst_n      - clock, synchronous active-low reset
//               load, load_val - start a new interval of load_val cycles
//               expire         - last cycle of the current interval
// Revision    : 1.0 - initial release
// ============================================================================
module spi_half_period_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expire
);

    logic [7:0] count;
    logic       running;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= 8'd0;
            running <= 1'b0;
        end else if (load) begin
            // Interval counts the current cycle, hence the minus one
            count   <= load_val - 8'd1;
            running <= 1'b1;
        end else if (running) begin
            if (count == 8'd0) begin
                running <= 1'b0;
            end else begin
                count <= count - 8'd1;
            end
        end
    end

    // Gated by running so an idle timer parked at zero never fires
    assign expire = running && (count == 8'd0);

endmodule
`default_nettype wire

// File: rtl/spi_config_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_config_master
// Description : Accepts one register write at a time over valid/ready and
//               sends it as a 16-bit SPI mode-0 write frame, MSB first.
//               SCLK half-period is CLK_DIV system clocks so a 2-flop
//               synchronised peripheral sees every edge.
// Ports       : clk, rst_n                  - clock, sync active-low reset
//               req_valid/req_ready         - request handshake
//               req_addr, req_data          - register address / data
//               busy, done                  - status, end-of-frame pulse
//               ncs, sclk, copi             - SPI pins (all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_config_master
    import spi_cfg_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       done,
    output logic       ncs,
    output logic       sclk,
    output logic       copi
);

    localparam logic [7:0] DIV_LOAD   = 8'(CLK_DIV);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES);
    localparam logic [4:0] LAST_BIT   = 5'(FRAME_BITS);
    localparam logic [4:0] LAST_SHIFT = 5'(FRAME_BITS - 1);

    spi_cfg_state_t state;
    logic [14:0]    pending;    // bits not yet on copi, next bit at [14]
    logic [4:0]     bit_cnt;    // completed HIGH phases
    logic [15:0]    frame;
    logic           accept;
    logic           tmr_load;
    logic [7:0]     tmr_val;
    logic           tmr_expire;

    assign frame  = build_frame(req_addr, req_data);
    assign accept = req_valid && req_ready;

    // Timer reloads on every state change; only the LOW->GAP transition
    // uses the gap length.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = DIV_LOAD;
        case (state)
            ST_IDLE:  tmr_load = accept;
            ST_SETUP: tmr_load = tmr_expire;
            ST_HIGH:  tmr_load = tmr_expire;
            ST_LOW: begin
                tmr_load = tmr_expire;
                if (bit_cnt == LAST_BIT) begin
                    tmr_val = GAP_LOAD;
                end
            end
            default: tmr_load = 1'b0;
        endcase
    end

    spi_half_period_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pending   <= 15'd0;
            bit_cnt   <= 5'd0;
            ncs       <= 1'b1;
            sclk      <= 1'b0;
            copi      <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        pending   <= frame[14:0];
                        copi      <= frame[15];
                        bit_cnt   <= 5'd0;
                        ncs       <= 1'b0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_expire) begin
                        sclk  <= 1'b1;
                        state <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tmr_expire) begin
                        sclk    <= 1'b0;
                        bit_cnt <= bit_cnt + 5'd1;
                        // Present the next bit on the falling edge; after
                        // the last bit copi holds bit 0 through the hold phase.
                        if (bit_cnt != LAST_SHIFT) begin
                            copi    <= pending[14];
                            pending <= {pending[13:0], 1'b0};
                        end
                        state <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (tmr_expire) begin
                        if (bit_cnt == LAST_BIT) begin
                            ncs   <= 1'b1;
                            copi  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_GAP;
                        end else begin
                            sclk  <= 1'b1;
                            state <= ST_HIGH;
                        end
                    end
                end
                ST_GAP: begin
                    if (tmr_expire) begin
                        bit_cnt   <= 5'd0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_config_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_config_master
// Description : Self-checking bench for spi_config_master. DUT0 uses the
//               default timing, DUT1 the minimum (CLK_DIV=2, GAP_CYCLES=2).
//               A synchronised peripheral model decodes the SPI pins of both.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_config_master;
    import spi_cfg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, prst;

    logic       req_valid, req_ready, busy, done, ncs, sclk, copi;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       req_valid1, req_ready1, busy1, done1, ncs1, sclk1, copi1;
    logic [6:0] req_addr1;
    logic [7:0] req_data1;

    spi_config_master #(.CLK_DIV(4), .GAP_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .busy(busy), .done(done),
        .ncs(ncs), .sclk(sclk), .copi(copi)
    );

    spi_config_master #(.CLK_DIV(2), .GAP_CYCLES(2)) dut_min (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_addr(req_addr1), .req_data(req_data1), .busy(busy1), .done(done1),
        .ncs(ncs1), .sclk(sclk1), .copi(copi1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- peripheral model (2-flop synchronised pins) ----------
    logic [1:0]            pin_sclk, pin_ncs, pin_copi;
    logic [1:0][2:0]       s_sclk, s_ncs;
    logic [1:0][1:0]       s_copi;
    logic [1:0][15:0]      p_shift;
    logic [1:0][4:0]       p_cnt;
    logic [1:0][4:0][7:0]  preg;
    assign pin_sclk = {sclk1, sclk};
    assign pin_ncs  = {ncs1, ncs};
    assign pin_copi = {copi1, copi};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (prst) begin
                s_sclk[d] <= 3'b000; s_ncs[d] <= 3'b111; s_copi[d] <= 2'b00;
                p_shift[d] <= 16'h0; p_cnt[d] <= 5'd0; preg[d] <= '0;
            end else begin
                s_sclk[d] <= {s_sclk[d][1:0], pin_sclk[d]};
                s_ncs[d]  <= {s_ncs[d][1:0], pin_ncs[d]};
                s_copi[d] <= {s_copi[d][0], pin_copi[d]};
                if (!s_ncs[d][1] && s_ncs[d][2]) begin
                    p_cnt[d] <= 5'd0;
                end else if (!s_ncs[d][1] && s_sclk[d][1] && !s_sclk[d][2]) begin
                    p_shift[d] <= {p_shift[d][14:0], s_copi[d][1]};
                    p_cnt[d]   <= p_cnt[d] + 5'd1;
                end
                if (s_ncs[d][1] && !s_ncs[d][2] && p_cnt[d] == 5'd16 &&
                    p_shift[d][15] && p_shift[d][14:8] <= 7'd4)
                    preg[d][p_shift[d][10:8]] <= p_shift[d][7:0];
            end
        end
    end

    // ---------------- pin monitor for DUT0 ---------------------------------
    logic        prev_ncs = 1'b1, prev_sclk = 1'b0;
    int          fall_t = 0, low_len = 0, done_t = 0, done_count = 0;
    int          fall_count = 0, nbits = 0, done1_t = 0;
    int          edge_t [16];
    logic [15:0] cap = 16'h0;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  exp_reg [5];

    always @(negedge clk) begin
        if (done === 1'b1) begin done_t = cyc; done_count++; end
        if (done1 === 1'b1) done1_t = cyc;
        if (prev_ncs && ncs === 1'b0) begin fall_t = cyc; nbits = 0; fall_count++; end
        if (!prev_ncs && ncs === 1'b1) begin
            low_len = cyc - fall_t;
            if (nbits == 16) got_q.push_back(cap);
        end
        if (ncs === 1'b0 && !prev_sclk && sclk === 1'b1) begin
            if (nbits < 16) edge_t[nbits] = cyc;
            cap = {cap[14:0], copi};
            nbits++;
        end
        prev_ncs  = (ncs !== 1'b0);
        prev_sclk = (sclk === 1'b1);
    end

    // ---------------- stimulus helpers (return at negedge + 1) -------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_req(input logic [6:0] a, input logic [7:0] d, output int t);
        req_addr = a; req_data = d; req_valid = 1'b1; t = -1;
        for (int i = 0; i < 400; i++) begin
            if (req_ready) begin t = cyc; break; end
            tick(1);
        end
        if (t < 0) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: req_ready=%b required 1 within 400 cycles", req_ready);
        end else begin
            tick(1);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_done(output int t);
        t = -1;
        for (int i = 0; i < 2000; i++) begin
            if (done) begin t = cyc; break; end
            tick(1);
        end
        if (t < 0) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout: done=%b required a pulse within 2000 cycles", done);
        end
    endtask

    task automatic wait_ready(output int t);
        t = -1;
        for (int i = 0; i < 400; i++) begin
            if (req_ready) begin t = cyc; break; end
            tick(1);
        end
    endtask

    // ---------------- tests -------------------------------------------------
    task automatic test_reset;
        rst_n = 1'b0; prst = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_data = '0;
        req_valid1 = 1'b0; req_addr1 = '0; req_data1 = '0;
        tick(3);
        n_cmp++; if (ncs !== 1'b1) begin n_err++; $display("FAIL reset_ncs: got %b required 1", ncs); end
        n_cmp++; if (sclk !== 1'b0) begin n_err++; $display("FAIL reset_sclk: got %b required 0", sclk); end
        n_cmp++; if (copi !== 1'b0) begin n_err++; $display("FAIL reset_copi: got %b required 0", copi); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b required 1", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b required 0", done); end
        n_cmp++; if ({ncs1, sclk1, busy1, done1, req_ready1} !== 5'b10001) begin
            n_err++; $display("FAIL reset_min: got %b required 10001", {ncs1, sclk1, busy1, done1, req_ready1});
        end
        rst_n = 1'b1; prst = 1'b0;
        for (int r = 0; r < 5; r++) exp_reg[r] = 8'h00;
        tick(2);
    endtask

    task automatic test_single_write;
        int t, td, tr;
        logic [15:0] f, e;
        exp_q.push_back(16'h8480);
        do_req(ADDR_PWM_DUTY, 8'h80, t);
        n_cmp++; if ({busy, req_ready, ncs, copi} !== 4'b1001) begin
            n_err++; $display("FAIL start_outputs: busy,ready,ncs,copi got %b required 1001", {busy, req_ready, ncs, copi});
        end
        wait_done(td);
        n_cmp++; if (td != t + 133) begin n_err++; $display("FAIL done_time: got T+%0d required T+133", td - t); end
        n_cmp++; if (ncs !== 1'b1) begin n_err++; $display("FAIL ncs_at_done: got %b required 1", ncs); end
        n_cmp++; if (low_len != 132) begin n_err++; $display("FAIL ncs_low_len: got %0d required 132", low_len); end
        n_cmp++; if (edge_t[0] != t + 5) begin n_err++; $display("FAIL edge0_time: got T+%0d required T+5", edge_t[0] - t); end
        n_cmp++; if (edge_t[15] != t + 125) begin n_err++; $display("FAIL edge15_time: got T+%0d required T+125", edge_t[15] - t); end
        if (got_q.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL single_frame: got none required %h", exp_q[0]);
            exp_q.delete();
        end else begin
            f = got_q.pop_front(); e = exp_q.pop_front();
            n_cmp++; if (f !== e) begin n_err++; $display("FAIL single_frame: got %h required %h", f, e); end
        end
        wait_ready(tr);
        n_cmp++; if (tr != t + 137) begin n_err++; $display("FAIL ready_time: got T+%0d required T+137", tr - t); end
        tick(8);
        exp_reg[4] = 8'h80;
        n_cmp++; if (preg[0][4] !== exp_reg[4]) begin n_err++; $display("FAIL pwm_duty: got %h required %h", preg[0][4], exp_reg[4]); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] dat [5];
        int ts [5];
        int td;
        logic [15:0] f, e;
        dat = '{8'hA5, 8'h5A, 8'hFF, 8'h0F, 8'h33};
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_addr = 7'(i); req_data = dat[i];
            exp_q.push_back({1'b1, 7'(i), dat[i]});
            ts[i] = -1;
            for (int k = 0; k < 400; k++) begin
                if (req_ready) begin ts[i] = cyc; break; end
                tick(1);
            end
            if (ts[i] < 0) begin
                n_cmp++; n_err++; $display("FAIL b2b_accept_timeout: request %0d not accepted", i);
                break;
            end
            tick(1);
        end
        req_valid = 1'b0;
        wait_done(td);
        tick(8);
        for (int i = 1; i < 5; i++) begin
            n_cmp++; if (ts[i] - ts[i-1] != 137) begin
                n_err++; $display("FAIL b2b_spacing%0d: got %0d required 137", i, ts[i] - ts[i-1]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                n_cmp++; n_err++; $display("FAIL b2b_frame%0d: got none required one", i);
            end else begin
                f = got_q.pop_front(); e = exp_q.pop_front();
                n_cmp++; if (f !== e) begin n_err++; $display("FAIL b2b_frame%0d: got %h required %h", i, f, e); end
            end
            exp_reg[i] = dat[i];
            n_cmp++; if (preg[0][i] !== exp_reg[i]) begin
                n_err++; $display("FAIL b2b_reg%0d: got %h required %h", i, preg[0][i], exp_reg[i]);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_busy_reject;
        int t, td, tr, f0;
        logic [15:0] f;
        f0 = fall_count;
        do_req(ADDR_EN_PWM_UO, 8'h3C, t);
        tick(10);
        req_addr = ADDR_EN_PWM_UIO; req_data = 8'h77; req_valid = 1'b1;
        tick(1);
        n_cmp++; if ({req_ready, busy} !== 2'b01) begin
            n_err++; $display("FAIL busy_ready: ready,busy got %b required 01", {req_ready, busy});
        end
        tick(2);
        req_valid = 1'b0;
        wait_done(td);
        wait_ready(tr);
        tick(20);
        n_cmp++; if (fall_count != f0 + 1) begin n_err++; $display("FAIL busy_frames: got %0d required 1", fall_count - f0); end
        if (got_q.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL busy_frame: got none required 823c");
        end else begin
            f = got_q.pop_front();
            n_cmp++; if (f !== 16'h823C) begin n_err++; $display("FAIL busy_frame: got %h required 823c", f); end
        end
        exp_reg[2] = 8'h3C;
        n_cmp++; if (preg[0][2] !== exp_reg[2]) begin n_err++; $display("FAIL busy_reg2: got %h required %h", preg[0][2], exp_reg[2]); end
        n_cmp++; if (preg[0][3] !== exp_reg[3]) begin n_err++; $display("FAIL busy_reg3: got %h required %h", preg[0][3], exp_reg[3]); end
    endtask

    task automatic test_reset_mid_frame;
        int t, d0, hit;
        d0 = done_count; hit = 0;
        do_req(ADDR_EN_OUT_UO, 8'h99, t);
        for (int i = 0; i < 200; i++) begin
            if (nbits == 8 && sclk) begin hit = 1; break; end
            tick(1);
        end
        n_cmp++; if (hit != 1) begin n_err++; $display("FAIL rst_edge7_timeout: got %0d edges required 8", nbits); end
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        n_cmp++; if ({ncs, sclk, req_ready, busy, done} !== 5'b10100) begin
            n_err++; $display("FAIL midrst_outputs: ncs,sclk,ready,busy,done got %b required 10100", {ncs, sclk, req_ready, busy, done});
        end
        tick(40);
        n_cmp++; if (done_count != d0) begin n_err++; $display("FAIL midrst_done: got %0d pulses required 0", done_count - d0); end
        n_cmp++; if (got_q.size() != 0) begin n_err++; $display("FAIL midrst_frames: got %0d required 0", got_q.size()); end
        n_cmp++; if (preg[0][0] !== exp_reg[0]) begin n_err++; $display("FAIL midrst_reg0: got %h required %h", preg[0][0], exp_reg[0]); end
        got_q.delete();
    endtask

    task automatic test_min_timing;
        int t, td, tr;
        t = -1; td = -1; tr = -1;
        req_addr1 = ADDR_EN_OUT_UIO; req_data1 = 8'hC3; req_valid1 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (req_ready1) begin t = cyc; break; end
            tick(1);
        end
        tick(1);
        req_valid1 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done1) begin td = cyc; break; end
            tick(1);
        end
        for (int i = 0; i < 50; i++) begin
            if (req_ready1) begin tr = cyc; break; end
            tick(1);
        end
        tick(10);
        n_cmp++; if (t < 0 || td != t + 67) begin n_err++; $display("FAIL min_done_time: got T+%0d required T+67", td - t); end
        n_cmp++; if (t < 0 || tr != t + 69) begin n_err++; $display("FAIL min_ready_time: got T+%0d required T+69", tr - t); end
        n_cmp++; if (preg[1][1] !== 8'hC3) begin n_err++; $display("FAIL min_en_out_uio: got %h required c3", preg[1][1]); end
    endtask

    task automatic test_unmapped;
        int t, td, tr, d0;
        logic [15:0] f;
        d0 = done_count;
        do_req(7'h7F, 8'h11, t);
        wait_done(td);
        wait_ready(tr);
        tick(8);
        n_cmp++; if (done_count != d0 + 1) begin n_err++; $display("FAIL unmapped_done: got %0d pulses required 1", done_count - d0); end
        if (got_q.size() == 0) begin
            n_cmp++; n_err++; $display("FAIL unmapped_frame: got none required ff11");
        end else begin
            f = got_q.pop_front();
            n_cmp++; if (f !== 16'hFF11) begin n_err++; $display("FAIL unmapped_frame: got %h required ff11", f); end
        end
        for (int r = 0; r < 5; r++) begin
            n_cmp++; if (preg[0][r] !== exp_reg[r]) begin
                n_err++; $display("FAIL unmapped_reg%0d: got %h required %h", r, preg[0][r], exp_reg[r]);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        #1;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_busy_reject();
        test_reset_mid_frame();
        test_min_timing();
        test_unmapped();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at 400000 ns, required completion");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire

// File: doc/spi_config_master.md
# spi_config_master

SPI controller that configures the SPI register peripheral (output enables, PWM enables, PWM duty cycle) from an on-chip requester. It accepts one register-write request at a time over a valid/ready handshake, then serialises it as a 16-bit write frame on `ncs`/`sclk`/`copi`. SCLK timing is derived from the system clock so that the peripheral's 2-flop synchronisers always see every edge. The block sits on the host/test-harness side, between a command source (boot sequencer, bench, or CPU bus bridge) and the peripheral pins.

## Interface
- `CLK_DIV`, 4, SCLK half-period in `clk` cycles; legal range 2..255.
- `GAP_CYCLES`, 4, minimum `ncs`-high cycles between frames; legal range 2..255.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `req_valid`  in  1  write request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_addr`  in  7  register address (0x00–0x04 defined; others are sent unchanged and ignored by the peripheral).
- `req_data`  in  8  register data.
- `busy`  out  1  high from the acceptance cycle until `req_ready` reasserts.
- `done`  out  1  one-cycle pulse when `ncs` deasserts at frame end.
- `ncs`  out  1  chip select, active low.
- `sclk`  out  1  serial clock, idle low (SPI mode 0).
- `copi`  out  1  serial data, MSB first.

## Operation
- Frame is `{1'b1, req_addr, req_data}` (bit 15 = write flag). The frame is latched into a 16-bit shift register on acceptance (`req_valid && req_ready`).
- FSM states:
  - IDLE: `ncs`=1, `sclk`=0, `req_ready`=1. On acceptance → SETUP.
  - SETUP: `ncs`=0, `sclk`=0, `copi`=frame[15], for CLK_DIV cycles → HIGH.
  - HIGH: `sclk`=1 for CLK_DIV cycles → LOW.
  - LOW: `sclk`=0 for CLK_DIV cycles.
    - If bits sent < 16, shift on entry so `copi` presents the next bit, then → HIGH.
    - After the 16th HIGH phase, this LOW phase is the hold phase: `copi` keeps bit 0, then → GAP.
  - GAP: `ncs`=1, `sclk`=0, `copi`=0. `done` pulses on the first GAP cycle. After GAP_CYCLES cycles → IDLE.
- `copi` changes only while `sclk` is low. It changes at SETUP entry and on the cycle `sclk` falls.
- Requests presented while `busy` are not accepted. The requester holds `req_*` stable until `req_ready`.
- Bit counter is 5 bits and counts completed HIGH phases (0..16). The divider counter is 8 bits and reloads on every state change.
- Reset mid-frame: on the next edge, outputs return to the IDLE values and the frame is discarded. The peripheral receives fewer than 16 bits and ignores the frame. No `done` pulse is issued.
- Reset values: `ncs`=1, `sclk`=0, `copi`=0, `req_ready`=1, `busy`=0, `done`=0, state IDLE, counters 0.

## Timing
- Acceptance at cycle T:
  - `ncs` falls at T+1.
  - Rising edge k (k=0..15) of `sclk` at T+1+CLK_DIV·(1+2k).
  - `ncs` rises and `done`=1 at T+1+33·CLK_DIV.
  - `req_ready` reasserts at T+1+33·CLK_DIV+GAP_CYCLES.
- With defaults: `ncs` low T+1..T+132, `done` at T+133, next acceptance possible at T+137. Throughput is one frame per 33·CLK_DIV+GAP_CYCLES+1 cycles.
- `req_valid` high in the same cycle `req_ready` reasserts is accepted that cycle; there are no idle bubbles beyond GAP.
- All outputs are registered; none is combinational from inputs.

## Structure
- Package `spi_cfg_pkg`:
  - Address constants `ADDR_EN_OUT_UO`=7'h00, `ADDR_EN_OUT_UIO`=7'h01, `ADDR_EN_PWM_UO`=7'h02, `ADDR_EN_PWM_UIO`=7'h03, `ADDR_PWM_DUTY`=7'h04.
  - `WRITE_FLAG`=1'b1 and `FRAME_BITS`=16.
  - FSM state enum `spi_cfg_state_t`.
- Sub-module `spi_half_period_timer`: loadable down-counter producing a one-cycle `expire` when CLK_DIV or GAP_CYCLES cycles have elapsed. It is shared by all timed states.

## Test plan
- Write addr 0x04, data 0x80 (defaults) → `copi` sampled on `sclk` rising edges reads 0x8480; `ncs` low exactly 132 cycles; `done` at T+133; peripheral model `pwm_duty_cycle`=0x80.
- Back-to-back: `req_valid` held high with five requests (0x00..0x04, data 0xA5,0x5A,0xFF,0x0F,0x33) → accepts spaced 137 cycles; all five peripheral registers match.
- `req_valid` pulsed while `busy` → `req_ready`=0 and no second frame; the original frame completes unchanged.
- `rst_n` low for one cycle at sclk edge 7 → next cycle `ncs`=1, `sclk`=0, `req_ready`=1, no `done`; peripheral registers unchanged.
- CLK_DIV=2, GAP_CYCLES=2, write addr 0x01 data 0xC3 → peripheral `en_out_uio`=0xC3, proving the minimum timing survives its synchronisers.
- Address 0x7F, data 0x11 → frame 0xFF11 sent normally, `done` pulses, peripheral registers unchanged.
